nx_fifo_rd_unpacker: RTL
========================

// Module: nx_fifo_rd_unpacker
// PURPOSE
//  Read-side stage directly downstream of the nx_fifo read port. Pops IN_W-bit entries
//  and serializes each into RATIO = ceil(IN_W/OUT_W) beats of OUT_W bits.
//  Beats leave on a valid/ready stream; out_last marks the final beat of each entry.
//  Sustains one beat per cycle with no bubble between consecutive entries.
// PARAMETERS
//  IN_W   263  FIFO entry width.
//  OUT_W  64   output beat width. RATIO = ceil(IN_W/OUT_W) = 5 at defaults.
//  CNT_W  $clog2(RATIO) (min 1)  width of the beat counter. Derived; not overridden.
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      asynchronous, active-high reset
//  clear       in   1      synchronous flush; drops the held entry
//  fifo_empty  in   1      FIFO empty flag
//  fifo_rdata  in   IN_W   FIFO head data; valid when fifo_empty=0
//  fifo_ren    out  1      FIFO pop strobe; combinational
//  out_valid   out  1      beat valid
//  out_ready   in   1      downstream accept
//  out_data    out  OUT_W  current beat
//  out_last    out  1      final beat of the current entry
//  out_idx     out  CNT_W  beat index within the entry, 0..RATIO-1
// BEHAVIOUR
//  - Reset: out_valid=0, out_last=0, out_idx=0, out_data=0, entry_q=0, state IDLE.
//    fifo_ren=0 while rst is asserted.
//  - Handshake: a beat transfers when out_valid && out_ready.
//    While out_valid=1 && out_ready=0, out_data, out_last and out_idx hold stable.
//    out_ready is ignored when out_valid=0.
//  - States:
//    IDLE: if !fifo_empty && !clear, assert fifo_ren, capture fifo_rdata into entry_q,
//      set cnt=0 and go to SEND. Latency: head visible at cycle t gives out_valid at t+1.
//    SEND: out_valid=1 and out_data=entry_q[cnt*OUT_W +: OUT_W].
//      On a transfer with cnt<RATIO-1, cnt increments.
//      On a transfer with cnt==RATIO-1 (out_last=1):
//        if !fifo_empty, assert fifo_ren the same cycle, reload entry_q, set cnt=0 and
//        stay in SEND (back-to-back, no bubble);
//        otherwise go to IDLE with out_valid=0 next cycle.
//  - Last beat: bits above IN_W are zero-padded. At defaults beat 4 = {57'b0, entry[262:256]}.
//  - fifo_ren is never asserted while fifo_empty=1, so the FIFO never underflows.
//    fifo_ren is at most 1 per cycle.
//  - clear has priority over everything except rst. Next cycle: IDLE, out_valid=0, cnt=0.
//    fifo_ren=0 in the clear cycle. The beat presented in the clear cycle is treated as
//    not transferred even if out_ready=1.
//  - rst asserted mid-entry: the partial entry is lost and the reset values apply
//    immediately (async). The FIFO is not popped again for that entry.
//  - RATIO==1: every beat has out_last=1 and the block acts as a 1-deep pipeline stage.
// CONFIGURATION
//  NX_FIFO_RD_UNPACKER_PERF_EN defined:
//    Adds outputs perf_entries[31:0] and perf_stalls[31:0].
//    perf_entries counts fifo_ren pulses. perf_stalls counts cycles with
//    out_valid && !out_ready. Both saturate at 32'hFFFF_FFFF, reset to 0 on rst and on clear.
//  Undefined: the ports and counters are absent. The datapath is identical in both cases.
// STRUCTURE
//  - nx_fifo_rd_unpacker_pkg holds:
//    typedef enum logic {UNPK_IDLE, UNPK_SEND} unpk_state_e;
//    function ceil_div(int a, int b) for RATIO;
//    localparam-style helper for CNT_W.
//  - Sub-module nx_sat_cnt32 (saturating 32-bit counter with clear), instantiated twice,
//    only under NX_FIFO_RD_UNPACKER_PERF_EN.
// TESTING (IN_W=263, OUT_W=64 unless noted)
//  1 Single entry: load entry 263'h1_2345...; out_ready=1 -> fifo_ren pulses once; 5 beats on
//    consecutive cycles; out_idx 0..4; out_last only on beat 4; beat 4 upper 57 bits = 0.
//  2 Back-to-back: 3 entries queued, out_ready=1 -> 15 consecutive beats with no gap;
//    fifo_ren pulses at cycles 0, 5, 10.
//  3 Backpressure: deassert out_ready for 3 cycles at beat 2 -> out_data and out_idx=2 held
//    stable; no extra fifo_ren; beat 2 transfers once when out_ready returns; with PERF_EN,
//    perf_stalls=3.
//  4 Empty boundary: FIFO drains after entry 1 -> out_valid=0 the cycle after the last beat;
//    fifo_ren stays 0 while empty; a new entry gives out_valid exactly 1 cycle after
//    fifo_empty falls.
//  5 Clear mid-entry: clear at beat 1 with out_ready=1 -> next cycle out_valid=0, no pop in the
//    clear cycle; the next entry restarts at out_idx=0; perf counters are 0.
//  6 Async reset at beat 3 -> outputs reach reset values with no clock edge; after release,
//    FIFO pops resume with the next queued entry.

Source files
------------

// File: rtl/nx_fifo_rd_unpacker_pkg.sv
// Shared types and sizing helpers for the nx_fifo read-side unpacker.
package nx_fifo_rd_unpacker_pkg;

    typedef enum logic {UNPK_IDLE, UNPK_SEND} unpk_state_e;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // A single-beat configuration still needs a one-bit counter.
    function automatic int cnt_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/nx_sat_cnt32.sv
// 32-bit event counter that sticks at all-ones and can be zeroed synchronously.
module nx_sat_cnt32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/nx_fifo_rd_unpacker.sv
// Pops wide nx_fifo entries and streams them out as OUT_W-bit beats, back-to-back.
// Optional perf counters are built when NX_FIFO_RD_UNPACKER_PERF_EN is defined.
module nx_fifo_rd_unpacker
    import nx_fifo_rd_unpacker_pkg::*;
#(
    parameter  int IN_W  = 263,
    parameter  int OUT_W = 64,
    localparam int RATIO = ceil_div(IN_W, OUT_W),
    localparam int CNT_W = cnt_width(RATIO)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             fifo_empty,
    input  logic [IN_W-1:0]  fifo_rdata,
    output logic             fifo_ren,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
`ifdef NX_FIFO_RD_UNPACKER_PERF_EN
    output logic [31:0]      perf_entries,
    output logic [31:0]      perf_stalls,
`endif
    output logic [CNT_W-1:0] out_idx
);

    localparam int               PAD_W    = RATIO * OUT_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATIO - 1);

    unpk_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IN_W-1:0]  entry_q, entry_d;
    logic             ren_c;
    logic [PAD_W-1:0] padded;
    logic [OUT_W-1:0] beats [RATIO];

    // Zero-extend so the final beat carries padding above IN_W.
    assign padded = PAD_W'(entry_q);

    for (genvar i = 0; i < RATIO; i++) begin : g_beat
        assign beats[i] = padded[i*OUT_W +: OUT_W];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        entry_d = entry_q;
        ren_c   = 1'b0;
        if (clear) begin
            state_d = UNPK_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                UNPK_IDLE: begin
                    if (!fifo_empty) begin
                        ren_c   = 1'b1;
                        entry_d = fifo_rdata;
                        cnt_d   = '0;
                        state_d = UNPK_SEND;
                    end
                end
                UNPK_SEND: begin
                    if (out_ready) begin
                        if (cnt_q == LAST_IDX) begin
                            cnt_d = '0;
                            // Reload on the last beat so consecutive entries leave without a bubble.
                            if (!fifo_empty) begin
                                ren_c   = 1'b1;
                                entry_d = fifo_rdata;
                            end else begin
                                state_d = UNPK_IDLE;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = UNPK_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= UNPK_IDLE;
            cnt_q   <= '0;
            entry_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            entry_q <= entry_d;
        end
    end

    // The pop strobe is combinational, so it must be masked while reset is held.
    assign fifo_ren  = ren_c && !rst;
    assign out_valid = (state_q == UNPK_SEND);
    assign out_last  = out_valid && (cnt_q == LAST_IDX);
    assign out_idx   = cnt_q;
    assign out_data  = out_valid ? beats[cnt_q] : '0;

`ifdef NX_FIFO_RD_UNPACKER_PERF_EN
    nx_sat_cnt32 u_perf_entries (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .inc   (fifo_ren),
        .count (perf_entries)
    );

    nx_sat_cnt32 u_perf_stalls (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .inc   (out_valid && !out_ready),
        .count (perf_stalls)
    );
`else
    // Counters are not built; the datapath above is unchanged.
`endif

endmodule
